counter_up_bcd2: RTL and testbench

Two-digit BCD elapsed-time up counter with a programmable terminal count. It is the counting-up counterpart of the timer's down-counting digit stages. The counter advances from a preset toward `limit_tens:limit_ones` and raises `done` when it gets there. It exports an active-low ripple carry (`rco_L`) so further digit stages can be cascaded above it.

---
 rtl/counter_up_bcd2_if.sv | 29 ++
 rtl/counter_up_bcd2.sv | 139 +++++++++++++
 tb/tb_counter_up_bcd2.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_up_bcd2_if.sv
// Bundle of the control, preset, limit and count signals of the two-digit
// BCD up counter. The master side drives controls and observes the count;
// the slave side is the counter itself.
interface counter_up_bcd2_if;
    logic       enablen;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] in_tens;
    logic [3:0] in_ones;
    logic [3:0] limit_tens;
    logic [3:0] limit_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       rco_L;
    logic       done;

    modport master (
        output enablen, load, start, pause,
        output in_tens, in_ones, limit_tens, limit_ones,
        input  tens, ones, rco_L, done
    );

    modport slave (
        input  enablen, load, start, pause,
        input  in_tens, in_ones, limit_tens, limit_ones,
        output tens, ones, rco_L, done
    );
endinterface

// File: rtl/counter_up_bcd2.sv
// Two-digit BCD up counter with a programmable terminal count.
// Counts from a preset toward limit_tens:limit_ones, parks in DONE on a
// post-increment match and exports an active-low ripple carry that is low
// exactly on the edge where the count wraps to 00.
module counter_up_bcd2 #(
    parameter int TENS_MOD = 6
) (
    input  logic              clk,
    input  logic              rst,
    counter_up_bcd2_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] TENS_TOP = 4'(TENS_MOD - 1);
    localparam logic [3:0] ONES_TOP = 4'd9;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       done_q, done_d;
    logic [3:0] inc_tens_s, inc_ones_s;
    logic       hit_limit_s;
    logic       wrap_s;

    // Replace an out-of-range preset digit with zero.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] top);
        if (d > top) begin
            clamp_digit = 4'd0;
        end else begin
            clamp_digit = d;
        end
    endfunction

    // Value the digits would take after one increment, with BCD carries.
    always_comb begin
        inc_tens_s = tens_q;
        inc_ones_s = ones_q + 4'd1;
        if (ones_q == ONES_TOP) begin
            inc_ones_s = 4'd0;
            if (tens_q == TENS_TOP) begin
                inc_tens_s = 4'd0;
            end else begin
                inc_tens_s = tens_q + 4'd1;
            end
        end else begin
            inc_tens_s = tens_q;
        end
        // An out-of-range limit can never equal a legal incremented value.
        hit_limit_s = (inc_tens_s == bus.limit_tens) && (inc_ones_s == bus.limit_ones);
    end

    // Next state and next digits; load beats every state-specific action.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (bus.load) begin
            tens_d  = clamp_digit(bus.in_tens, TENS_TOP);
            ones_d  = clamp_digit(bus.in_ones, ONES_TOP);
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_HOLD;
                    end else if (!bus.enablen) begin
                        tens_d = inc_tens_s;
                        ones_d = inc_ones_s;
                        if (hit_limit_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    // State, digit and done registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    // Carry is live in the same cycle so a cascaded stage counts on the wrap edge.
    assign wrap_s = (state_q == ST_RUN) && !bus.pause && !bus.enablen &&
                    (tens_q == TENS_TOP) && (ones_q == ONES_TOP);

    assign bus.rco_L = !wrap_s;
    assign bus.tens  = tens_q;
    assign bus.ones  = ones_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_up_bcd2.sv
// Self-checking bench for counter_up_bcd2 (TENS_MOD = 6): a directed vector
// table, hand-written wrap sequences, and random stimulus compared against
// an arithmetic model that treats the count as a single integer 0..59.
module tb_counter_up_bcd2;

    localparam int TM   = 6;
    localparam int SPAN = TM * 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_up_bcd2_if bus ();

    counter_up_bcd2 #(.TENS_MOD(TM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: value as one integer, mode as 0 idle, 1 run, 2 hold, 3 done.
    int m_val = 0;
    int m_st  = 0;

    typedef struct {
        logic       rst;
        logic       load;
        logic       start;
        logic       pause;
        logic       enablen;
        logic [3:0] it;
        logic [3:0] io;
        logic [3:0] lt;
        logic [3:0] lo;
        logic [3:0] et;
        logic [3:0] eo;
        logic       ed;
        logic       erco;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic ld, input logic st, input logic pa,
                                input logic en, input int it, input int io, input int lt,
                                input int lo, input int et, input int eo, input logic ed,
                                input logic erco);
        vec_t v;
        v.rst = r; v.load = ld; v.start = st; v.pause = pa; v.enablen = en;
        v.it = 4'(it); v.io = 4'(io); v.lt = 4'(lt); v.lo = 4'(lo);
        v.et = 4'(et); v.eo = 4'(eo); v.ed = ed; v.erco = erco;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic st, input logic pa,
                         input logic en, input int it, input int io, input int lt, input int lo);
        rst            = r;
        bus.load       = ld;
        bus.start      = st;
        bus.pause      = pa;
        bus.enablen    = en;
        bus.in_tens    = 4'(it);
        bus.in_ones    = 4'(io);
        bus.limit_tens = 4'(lt);
        bus.limit_ones = 4'(lo);
    endtask

    // Apply the rules to the inputs present at the clock edge.
    task automatic model_edge();
        int lt, lo, it, io;
        lt = int'(bus.limit_tens);
        lo = int'(bus.limit_ones);
        it = int'(bus.in_tens);
        io = int'(bus.in_ones);
        if (!rst) begin
            m_val = 0;
            m_st  = 0;
        end else if (bus.load) begin
            m_val = ((it < TM) ? it : 0) * 10 + ((io <= 9) ? io : 0);
            m_st  = 0;
        end else begin
            case (m_st)
                0: if (bus.start) m_st = 1;
                1: begin
                    if (bus.pause) begin
                        m_st = 2;
                    end else if (!bus.enablen) begin
                        m_val = (m_val + 1) % SPAN;
                        if (lt < TM && lo <= 9 && m_val == lt * 10 + lo) m_st = 3;
                    end
                end
                2: if (!bus.pause) m_st = 1;
                3: begin
                    if (bus.start) begin
                        m_val = 0;
                        m_st  = 1;
                    end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    function automatic int model_rco();
        return (m_st == 1 && !bus.pause && !bus.enablen && m_val == SPAN - 1) ? 0 : 1;
    endfunction

    // One clock checked against the model: carry before the edge, registers after it.
    task automatic cycle_model(input string tag);
        #1;
        check({tag, ".rco_L"}, int'(bus.rco_L), model_rco());
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".tens"}, int'(bus.tens), m_val / 10);
        check({tag, ".ones"}, int'(bus.ones), m_val % 10);
        check({tag, ".done"}, int'(bus.done), (m_st == 3) ? 1 : 0);
    endtask

    initial begin
        int lt_r, lo_r;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 5);

        // Count up to 0:5 and stay there.
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1));
        for (int k = 1; k <= 5; k++)
            vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, k, (k == 5), 1));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 5, 1, 1));
        // Preset 58, unreachable limit: 59, wrap to 00 with carry, 01.
        vt.push_back(mk(1, 1, 0, 0, 1, 5, 8, 9, 9, 5, 8, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 1, 0, 0, 9, 9, 5, 8, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 5, 9, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 0, 1, 0, 1));
        // Out-of-range preset clears to 00 and parks in IDLE.
        vt.push_back(mk(1, 1, 0, 0, 0, 7, 12, 9, 9, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 1));
        // Run to 03, pause four edges, resume, then enable off.
        vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1));
        for (int k = 1; k <= 3; k++)
            vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, k, 0, 1));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 9, 0, 3, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 3, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 4, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 9, 0, 4, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 9, 0, 4, 0, 1));
        // Reach 0:5, restart from DONE to 00, then 01.
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 5, 1, 1));
        vt.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1));
        // Reset with load and start mid-count at 34.
        vt.push_back(mk(1, 1, 0, 0, 1, 3, 2, 9, 9, 3, 2, 0, 1));
        vt.push_back(mk(1, 0, 1, 0, 1, 0, 0, 9, 9, 3, 2, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 3, 3, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 3, 4, 0, 1));
        vt.push_back(mk(0, 1, 1, 0, 0, 5, 5, 9, 9, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, 1));

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].load, vt[i].start, vt[i].pause, vt[i].enablen,
                  int'(vt[i].it), int'(vt[i].io), int'(vt[i].lt), int'(vt[i].lo));
            #1;
            check($sformatf("vec%0d.rco_L", i), int'(bus.rco_L), int'(vt[i].erco));
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d.tens", i), int'(bus.tens), int'(vt[i].et));
            check($sformatf("vec%0d.ones", i), int'(bus.ones), int'(vt[i].eo));
            check($sformatf("vec%0d.done", i), int'(bus.done), int'(vt[i].ed));
        end

        // Preset equal to the limit must go all the way round before DONE.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 0, 3);
        cycle_model("eqlim.load");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 3);
        cycle_model("eqlim.start");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 3);
        for (int k = 1; k < SPAN; k++) begin
            cycle_model("eqlim.run");
        end
        check("eqlim.not_done_before", int'(bus.done), 0);
        cycle_model("eqlim.last");
        check("eqlim.final_tens", int'(bus.tens), 0);
        check("eqlim.final_ones", int'(bus.ones), 3);
        check("eqlim.final_done", int'(bus.done), 1);

        // Out-of-range limit tens free-runs through two full wraps.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 6, 0);
        cycle_model("freerun.load");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 6, 0);
        cycle_model("freerun.start");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 6, 0);
        for (int k = 0; k < 2 * SPAN + 5; k++) begin
            cycle_model("freerun.run");
        end
        check("freerun.done", int'(bus.done), 0);
        check("freerun.ones", int'(bus.ones), 5);

        // Random traffic against the model; limits change occasionally.
        lt_r = 0;
        lo_r = 7;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(29, 0) == 0) begin
                if ($urandom_range(7, 0) == 0) begin
                    lt_r = $urandom_range(15, 0);
                    lo_r = $urandom_range(15, 0);
                end else begin
                    lt_r = $urandom_range(TM - 1, 0);
                    lo_r = $urandom_range(9, 0);
                end
            end
            drive(($urandom_range(79, 0) != 0),
                  ($urandom_range(24, 0) == 0),
                  ($urandom_range(9, 0) == 0),
                  ($urandom_range(7, 0) == 0),
                  ($urandom_range(4, 0) == 0),
                  $urandom_range(15, 0), $urandom_range(15, 0), lt_r, lo_r);
            cycle_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
